// File: rtl/uart_string_loopback.sv
// UART-to-AES bridge: gathers 16 received bytes into a block, encrypts it with
// AES-128 under a fixed key and streams the 16 ciphertext bytes back out, MSB first.

module aes128_encrypt (
  input  logic         clk,
  input  logic         i_srst,
  input  logic         i_start,
  input  logic [127:0] i_plaintext,
  input  logic [127:0] i_key,
  output logic         o_valid,
  output logic [127:0] o_ciphertext
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bits 2047-8x, i.e. index {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [127:0] r_state, r_rk;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic         r_busy;
  logic [127:0] w_sub, w_shift, w_mix, w_rk_next;
  logic [31:0]  w_rot, w_key_sub, w_t;

  // One full round per clock; the round key is expanded alongside the data path.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign w_sub[127-8*gi -: 8]   = sbox(r_state[127-8*gi -: 8]);
    assign w_shift[127-8*gi -: 8] = w_sub[127-8*(gi%4 + 4*((gi/4 + gi%4)%4)) -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_shift[127-32*gi -: 8];
    assign w_a1 = w_shift[119-32*gi -: 8];
    assign w_a2 = w_shift[111-32*gi -: 8];
    assign w_a3 = w_shift[103-32*gi -: 8];
    assign w_mix[127-32*gi -: 32] = {
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
    };
  end

  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  for (genvar gi = 0; gi < 4; gi++) begin : g_key_sub
    assign w_key_sub[31-8*gi -: 8] = sbox(w_rot[31-8*gi -: 8]);
  end
  assign w_t = w_key_sub ^ {r_rcon, 24'h000000};
  assign w_rk_next[127:96] = r_rk[127:96] ^ w_t;
  assign w_rk_next[95:64]  = r_rk[95:64] ^ w_rk_next[127:96];
  assign w_rk_next[63:32]  = r_rk[63:32] ^ w_rk_next[95:64];
  assign w_rk_next[31:0]   = r_rk[31:0] ^ w_rk_next[63:32];

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_state <= '0;
      r_rk    <= '0;
      r_round <= '0;
      r_rcon  <= '0;
      r_busy  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_start && !r_busy) begin
        r_state <= i_plaintext ^ i_key;
        r_rk    <= i_key;
        r_round <= 4'd1;
        r_rcon  <= 8'h01;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_state <= ((r_round == 4'd10) ? w_shift : w_mix) ^ w_rk_next;
        r_rk    <= w_rk_next;
        r_rcon  <= xtime(r_rcon);
        r_round <= r_round + 4'd1;
        if (r_round == 4'd10) begin
          r_busy  <= 1'b0;
          o_valid <= 1'b1;
        end
      end
    end
  end

  assign o_ciphertext = r_state;
endmodule

module uart_string_loopback #(
  parameter int           CLK_FREQ     = 100_000_000,
  parameter int           BAUD_RATE    = 115_200,
  parameter int           CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter logic [127:0] KEY          = 128'h000102030405060708090a0b0c0d0e0f
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic tx
);
  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [2:0] {S_COLLECT, S_START, S_WAIT, S_SEND, S_TXWAIT} state_t;

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift, r_rx_byte;
  logic          r_rx_done;

  logic          r_tx, r_tx_busy, r_tx_done, r_tx_start;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;
  logic [7:0]    r_tx_data;

  state_t        r_state;
  logic [127:0]  r_block;
  logic [3:0]    r_rx_count, r_tx_idx;
  logic [127:0]  last_plaintext, last_ciphertext;
  logic          aes_start, aes_valid_out;
  logic [127:0]  w_ct;
  logic [127:0]  w_block_next;
  logic [3:0]    w_idx_next;
  logic [7:0]    w_tx_byte, w_tx_byte_next;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_rx_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev && !r_rx_sync) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
        end
        // A start bit that is high again at mid-bit is treated as line noise.
        RX_START: if (r_rx_cnt == HALF_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_DATA: if (r_rx_cnt == BIT_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_STOP: if (r_rx_cnt == BIT_LAST) begin
          r_rx_cnt <= '0;
          if (r_rx_sync) begin
            r_rx_done  <= 1'b1;
            r_rx_byte  <= r_rx_shift;
            r_rx_state <= RX_IDLE;
          end else r_rx_state <= RX_WAIT_HIGH;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_WAIT_HIGH: if (r_rx_sync) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        r_tx <= 1'b1;
        if (r_tx_start) begin
          r_tx       <= 1'b0;
          r_tx_shift <= {1'b1, r_tx_data};
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_tx_busy  <= 1'b1;
        end
      end else if (r_tx_cnt == BIT_LAST) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end else begin
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bit   <= r_tx_bit + 4'd1;
        end
      end else r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  assign tx             = r_tx;
  assign w_block_next   = {r_block[119:0], r_rx_byte};
  assign w_idx_next     = r_tx_idx + 4'd1;
  assign w_tx_byte      = last_ciphertext[{~r_tx_idx, 3'b111} -: 8];
  assign w_tx_byte_next = last_ciphertext[{~w_idx_next, 3'b111} -: 8];

  // Back-to-back frames: the next byte is queued the cycle the previous stop bit ends.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state         <= S_COLLECT;
      r_block         <= '0;
      r_rx_count      <= '0;
      r_tx_idx        <= '0;
      r_tx_start      <= 1'b0;
      r_tx_data       <= '0;
      last_plaintext  <= '0;
      last_ciphertext <= '0;
      aes_start       <= 1'b0;
    end else begin
      aes_start  <= 1'b0;
      r_tx_start <= 1'b0;
      case (r_state)
        S_COLLECT: if (r_rx_done) begin
          r_block    <= w_block_next;
          r_rx_count <= r_rx_count + 4'd1;
          if (r_rx_count == 4'd15) begin
            last_plaintext <= w_block_next;
            r_state        <= S_START;
          end
        end
        S_START: begin
          aes_start <= 1'b1;
          r_state   <= S_WAIT;
        end
        S_WAIT: if (aes_valid_out) begin
          last_ciphertext <= w_ct;
          r_tx_idx        <= '0;
          r_state         <= S_SEND;
        end
        S_SEND: begin
          r_tx_start <= 1'b1;
          r_tx_data  <= w_tx_byte;
          r_state    <= S_TXWAIT;
        end
        S_TXWAIT: if (r_tx_done) begin
          if (r_tx_idx == 4'd15) r_state <= S_COLLECT;
          else begin
            r_tx_idx   <= w_idx_next;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_tx_byte_next;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  aes128_encrypt u_aes (
    .clk          (clk),
    .i_srst       (rst_n),
    .i_start      (aes_start),
    .i_plaintext  (last_plaintext),
    .i_key        (KEY),
    .o_valid      (aes_valid_out),
    .o_ciphertext (w_ct)
  );
endmodule

// File: tb/tb_uart_string_loopback.sv
// Scoreboard bench for uart_string_loopback: expected TX bytes are queued at
// stimulus time and popped by an independent UART TX monitor.

module tb_uart_string_loopback;
  localparam int           CPB     = 16;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_CNT  = 128'h1112131415161718191a1b1c1d1e1f20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx = 1'b1;
  logic tx;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int aes_pulses = 0;
  bit tx_low_seen = 1'b0;
  int exp_q[$];

  uart_string_loopback #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .KEY       (128'h000102030405060708090a0b0c0d0e0f)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  initial begin : aes_pulse_counter
    forever begin
      @(negedge clk);
      if (dut.aes_valid_out === 1'b1) aes_pulses++;
    end
  end

  initial begin : tx_monitor
    bit         m_active;
    int         m_cnt;
    int         m_bit;
    int         e;
    logic [7:0] m_data;
    m_active = 1'b0;
    m_cnt = 0;
    m_bit = 0;
    m_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        m_active = 1'b0;
      end else begin
        if (tx === 1'b0) tx_low_seen = 1'b1;
        if (!m_active) begin
          if (tx === 1'b0) begin
            m_active = 1'b1;
            m_cnt = 0;
            m_bit = 0;
          end
        end else begin
          m_cnt++;
          if (m_cnt == CPB/2 + m_bit*CPB) begin
            if (m_bit == 0) begin
              check("tx_start_bit", 128'(tx), 128'(0));
            end else if (m_bit <= 8) begin
              m_data[m_bit-1] = tx;
            end else begin
              check("tx_stop_bit", 128'(tx), 128'(1));
              frames++;
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected_frame: got byte %02h required no frame", m_data);
              end else begin
                e = exp_q.pop_front();
                if (e >= 0) check($sformatf("tx_byte%0d", frames-1), 128'(m_data), 128'(e));
                else $display("tx frame %0d byte %02h", frames-1, m_data);
              end
              m_active = 1'b0;
            end
            m_bit++;
          end
        end
      end
    end
  end

  task automatic rx_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop_val);
    rx_bit(1'b1);
    $display("rx sent byte %02h stop=%0d", b, stop_val);
  endtask

  task automatic send_range(input logic [127:0] blk, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(blk[127-8*i -: 8], 1'b1);
  endtask

  task automatic send_glitch();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
    $display("rx sent glitch");
  endtask

  task automatic push_expected(input logic [127:0] ct, input bit known);
    for (int i = 0; i < 16; i++) exp_q.push_back(known ? int'(ct[127-8*i -: 8]) : -1);
  endtask

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while ((frames < target || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (2*CPB) @(negedge clk);
    check(name, 128'(frames), 128'(target));
  endtask

  initial begin : stimulus
    int p0;
    int n;
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    check("reset_tx", 128'(tx), 128'(1));
    check("reset_last_plaintext", dut.last_plaintext, 128'h0);
    check("reset_last_ciphertext", dut.last_ciphertext, 128'h0);
    tx_low_seen = 1'b0;
    repeat (2000) @(negedge clk);
    check("idle_tx_low_seen", 128'(tx_low_seen), 128'(0));
    check("idle_aes_pulses", 128'(aes_pulses), 128'(0));

    // FIPS-197 known-answer block
    frames = 0;
    p0 = aes_pulses;
    push_expected(CT_FIPS, 1'b1);
    send_range(PT_FIPS, 0, 15);
    wait_frames(16, "fips_frames");
    check("fips_last_plaintext", dut.last_plaintext, PT_FIPS);
    check("fips_last_ciphertext", dut.last_ciphertext, CT_FIPS);
    check("fips_aes_pulses", 128'(aes_pulses - p0), 128'(1));

    // Byte ordering / counting block
    frames = 0;
    p0 = aes_pulses;
    push_expected(128'h0, 1'b0);
    send_range(PT_CNT, 0, 15);
    wait_frames(16, "count_frames");
    check("count_last_plaintext", dut.last_plaintext, PT_CNT);
    repeat (400) @(negedge clk);
    check("count_aes_pulses", 128'(aes_pulses - p0), 128'(1));
    check("count_no_extra_frames", 128'(frames), 128'(16));

    // Partial block: 15 bytes must not trigger anything
    frames = 0;
    p0 = aes_pulses;
    tx_low_seen = 1'b0;
    send_range(PT_FIPS, 0, 14);
    repeat (300) @(negedge clk);
    check("partial_aes_pulses", 128'(aes_pulses - p0), 128'(0));
    check("partial_tx_low_seen", 128'(tx_low_seen), 128'(0));
    push_expected(CT_FIPS, 1'b1);
    send_range(PT_FIPS, 15, 15);
    wait_frames(16, "partial_frames");
    check("partial_last_ciphertext", dut.last_ciphertext, CT_FIPS);
    check("partial_aes_pulses_done", 128'(aes_pulses - p0), 128'(1));

    // Framing error and glitch are not counted as bytes
    frames = 0;
    p0 = aes_pulses;
    tx_low_seen = 1'b0;
    send_range(PT_FIPS, 0, 6);
    send_byte(8'ha5, 1'b0);
    send_glitch();
    send_range(PT_FIPS, 7, 14);
    repeat (300) @(negedge clk);
    check("framing_aes_pulses", 128'(aes_pulses - p0), 128'(0));
    check("framing_tx_low_seen", 128'(tx_low_seen), 128'(0));
    push_expected(CT_FIPS, 1'b1);
    send_range(PT_FIPS, 15, 15);
    wait_frames(16, "framing_frames");
    check("framing_last_plaintext", dut.last_plaintext, PT_FIPS);
    check("framing_aes_pulses_done", 128'(aes_pulses - p0), 128'(1));

    // Reset during ciphertext byte 5, then a fresh block
    frames = 0;
    push_expected(CT_FIPS, 1'b1);
    send_range(PT_FIPS, 0, 15);
    n = 0;
    while (!(frames == 5 && tx === 1'b0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("midtx_reached_byte5", 128'(frames), 128'(5));
    rst_n = 1'b1;
    @(negedge clk);
    check("midtx_tx_high_after_reset", 128'(tx), 128'(1));
    check("midtx_last_ciphertext_cleared", dut.last_ciphertext, 128'h0);
    exp_q.delete();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (2*CPB) @(negedge clk);
    frames = 0;
    p0 = aes_pulses;
    push_expected(CT_FIPS, 1'b1);
    send_range(PT_FIPS, 0, 15);
    wait_frames(16, "after_reset_frames");
    check("after_reset_last_ciphertext", dut.last_ciphertext, CT_FIPS);
    check("after_reset_aes_pulses", 128'(aes_pulses - p0), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
